fbw_sink: RTL and testbench

//  Responder end of the frame-buffer write interface. Accepts pixel writes into

---
 rtl/fbw_pkg.sv | 14 +
 rtl/fbw_line_buf.sv | 38 +++
 rtl/fbw_sink.sv | 131 +++++++++++++
 tb/tb_fbw_sink.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbw_pkg.sv
// Shared defaults and copy-engine state encoding for the frame-buffer write sink.
package fbw_pkg;

    localparam int unsigned DEF_ROW_BITS = 6;
    localparam int unsigned DEF_COL_BITS = 6;
    localparam int unsigned DEF_DATA_W   = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        COPY  = 2'd2
    } copy_state_t;

endpackage

// File: rtl/fbw_line_buf.sv
// Ping-pong line buffer: two banks of one row each, one write port and one
// registered (1-cycle) read port, each with its own bank select.
module fbw_line_buf
    import fbw_pkg::*;
#(
    parameter int unsigned COL_BITS = DEF_COL_BITS,
    parameter int unsigned DATA_W   = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                wr_bank,
    input  logic [COL_BITS-1:0] wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic                rd_bank,
    input  logic [COL_BITS-1:0] rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] mem [2**(COL_BITS+1)];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Read register holds its value when rd_en is low, so it can drive a stalled bus directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/fbw_sink.sv
// Frame-buffer write responder: fills line buffers, copies stored rows into the
// back frame, and swaps front/back frames on display vsync.
module fbw_sink
    import fbw_pkg::*;
#(
    parameter int unsigned ROW_BITS = DEF_ROW_BITS,
    parameter int unsigned COL_BITS = DEF_COL_BITS,
    parameter int unsigned DATA_W   = DEF_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            fbw_data,
    input  logic [COL_BITS-1:0]          fbw_col_addr,
    input  logic                         fbw_wren,
    input  logic [ROW_BITS-1:0]          fbw_row_addr,
    input  logic                         fbw_row_store,
    input  logic                         fbw_row_swap,
    output logic                         fbw_row_rdy,
    input  logic                         frame_swap,
    output logic                         frame_rdy,
    input  logic                         disp_vsync,
    output logic                         disp_frame,
    output logic [ROW_BITS+COL_BITS:0]   fbm_addr,
    output logic [DATA_W-1:0]            fbm_data,
    output logic                         fbm_we,
    input  logic                         fbm_rdy
);

    localparam logic [COL_BITS-1:0] LAST_COL = '1;

    copy_state_t         state;
    logic                fill_sel;
    logic                src_sel;
    logic                swap_pending;
    logic [ROW_BITS-1:0] row_q;
    logic [COL_BITS-1:0] col_q;
    logic [COL_BITS-1:0] col_nxt;
    logic                rd_en;
    logic [COL_BITS-1:0] rd_addr;

    // Read col 0 while priming; in COPY prefetch col+1 only when the current word is accepted.
    always_comb begin
        col_nxt = col_q + 1'b1;
        rd_en   = 1'b0;
        rd_addr = col_nxt;
        unique case (state)
            PRIME: begin
                rd_en   = 1'b1;
                rd_addr = '0;
            end
            COPY:    rd_en = fbm_rdy && (col_q != LAST_COL);
            default: rd_en = 1'b0;
        endcase
    end

    fbw_line_buf #(
        .COL_BITS (COL_BITS),
        .DATA_W   (DATA_W)
    ) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fbw_wren),
        .wr_bank (fill_sel),
        .wr_addr (fbw_col_addr),
        .wr_data (fbw_data),
        .rd_en   (rd_en),
        .rd_bank (src_sel),
        .rd_addr (rd_addr),
        .rd_data (fbm_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            fbw_row_rdy  <= 1'b1;
            fill_sel     <= 1'b0;
            src_sel      <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            fbm_we       <= 1'b0;
            fbm_addr     <= '0;
            frame_rdy    <= 1'b1;
            swap_pending <= 1'b0;
            disp_frame   <= 1'b0;
        end else begin
            if (fbw_row_swap && fbw_row_rdy) begin
                fill_sel <= ~fill_sel;
            end

            if (frame_swap && !swap_pending) begin
                swap_pending <= 1'b1;
                frame_rdy    <= 1'b0;
            end else if (disp_vsync && swap_pending && state == IDLE) begin
                disp_frame   <= ~disp_frame;
                swap_pending <= 1'b0;
                frame_rdy    <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (fbw_row_store && fbw_row_rdy) begin
                        row_q       <= fbw_row_addr;
                        src_sel     <= fill_sel;
                        col_q       <= '0;
                        fbw_row_rdy <= 1'b0;
                        state       <= PRIME;
                    end
                end
                PRIME: begin
                    fbm_we   <= 1'b1;
                    fbm_addr <= {~disp_frame, row_q, col_q};
                    state    <= COPY;
                end
                COPY: begin
                    if (fbm_rdy) begin
                        if (col_q == LAST_COL) begin
                            fbm_we      <= 1'b0;
                            fbw_row_rdy <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            col_q    <= col_nxt;
                            fbm_addr <= {~disp_frame, row_q, col_nxt};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fbw_sink.sv
// Self-checking bench for fbw_sink: line-buffer model plus expected write queue.
module tb_fbw_sink;

    localparam int NCOL = 64;

    typedef struct packed {
        logic [12:0] addr;
        logic [23:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic [23:0] fbw_data;
    logic [5:0]  fbw_col_addr;
    logic        fbw_wren;
    logic [5:0]  fbw_row_addr;
    logic        fbw_row_store;
    logic        fbw_row_swap;
    logic        fbw_row_rdy;
    logic        frame_swap;
    logic        frame_rdy;
    logic        disp_vsync;
    logic        disp_frame;
    logic [12:0] fbm_addr;
    logic [23:0] fbm_data;
    logic        fbm_we;
    logic        fbm_rdy;

    int checks = 0;
    int errors = 0;

    logic [23:0] m_lb [2][NCOL];
    bit          m_fill = 1'b0;
    bit          m_disp = 1'b0;
    wr_t         exp_q[$];

    fbw_sink #(
        .ROW_BITS (6),
        .COL_BITS (6),
        .DATA_W   (24)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fbw_data      (fbw_data),
        .fbw_col_addr  (fbw_col_addr),
        .fbw_wren      (fbw_wren),
        .fbw_row_addr  (fbw_row_addr),
        .fbw_row_store (fbw_row_store),
        .fbw_row_swap  (fbw_row_swap),
        .fbw_row_rdy   (fbw_row_rdy),
        .frame_swap    (frame_swap),
        .frame_rdy     (frame_rdy),
        .disp_vsync    (disp_vsync),
        .disp_frame    (disp_frame),
        .fbm_addr      (fbm_addr),
        .fbm_data      (fbm_data),
        .fbm_we        (fbm_we),
        .fbm_rdy       (fbm_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_pix(input int c, input logic [23:0] d);
        fbw_wren     = 1'b1;
        fbw_col_addr = 6'(c);
        fbw_data     = d;
        tick();
        fbw_wren = 1'b0;
        m_lb[m_fill][c] = d;
    endtask

    // A store snapshots the whole fill row into the expected write stream.
    task automatic store(input int row, input bit swap);
        wr_t e;
        fbw_row_store = 1'b1;
        fbw_row_addr  = 6'(row);
        fbw_row_swap  = swap;
        tick();
        fbw_row_store = 1'b0;
        fbw_row_swap  = 1'b0;
        for (int c = 0; c < NCOL; c++) begin
            e.addr = {~m_disp, 6'(row), 6'(c)};
            e.data = m_lb[m_fill][c];
            exp_q.push_back(e);
        end
        if (swap) m_fill = ~m_fill;
    endtask

    task automatic drain(input int mode, input bit wr_other, input int vs_cyc, input int exp_cycles);
        int          cyc;
        int          c;
        bit          held;
        logic [12:0] h_addr;
        logic [23:0] h_data;
        logic [23:0] d;
        wr_t         e;
        cyc  = 0;
        held = 1'b0;
        while (exp_q.size() != 0 && cyc < 1000) begin
            if (mode == 0)      fbm_rdy = 1'b1;
            else if (mode == 1) fbm_rdy = ~cyc[0];
            else                fbm_rdy = 1'($urandom_range(0, 1));
            disp_vsync = (cyc == vs_cyc);
            if (wr_other) begin
                c = $urandom_range(0, NCOL - 1);
                d = 24'($urandom);
                fbw_wren     = 1'b1;
                fbw_col_addr = 6'(c);
                fbw_data     = d;
                m_lb[m_fill][c] = d;
            end
            if (held) begin
                check("stall_we", fbm_we, 1);
                check("stall_addr", fbm_addr, h_addr);
                check("stall_data", fbm_data, h_data);
            end
            held = 1'b0;
            if (fbm_we && fbm_rdy) begin
                e = exp_q.pop_front();
                check("wr_addr", fbm_addr, e.addr);
                check("wr_data", fbm_data, e.data);
            end else if (fbm_we) begin
                held   = 1'b1;
                h_addr = fbm_addr;
                h_data = fbm_data;
            end
            tick();
            cyc++;
        end
        fbw_wren   = 1'b0;
        disp_vsync = 1'b0;
        fbm_rdy    = 1'b1;
        check("drain_timeout", exp_q.size(), 0);
        if (exp_cycles > 0) check("copy_cycles", cyc, exp_cycles);
        check("rdy_after_copy", fbw_row_rdy, 1);
        check("we_after_copy", fbm_we, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        fbw_data      = '0;
        fbw_col_addr  = '0;
        fbw_wren      = 1'b0;
        fbw_row_addr  = '0;
        fbw_row_store = 1'b0;
        fbw_row_swap  = 1'b0;
        frame_swap    = 1'b0;
        disp_vsync    = 1'b0;
        fbm_rdy       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("rst_row_rdy", fbw_row_rdy, 1);
        check("rst_frame_rdy", frame_rdy, 1);
        check("rst_disp", disp_frame, 0);
        check("rst_we", fbm_we, 0);
        check("rst_addr", fbm_addr, 0);
        check("rst_data", fbm_data, 0);

        // Row 5 = col*3, full-rate copy: writes in cycles 2..65.
        for (int c = 0; c < NCOL; c++) wr_pix(c, 24'(c * 3));
        store(5, 1'b1);
        check("t1_rdy_c1", fbw_row_rdy, 0);
        check("t1_we_c1", fbm_we, 0);
        tick();
        drain(0, 1'b0, -1, 64);

        // Same row with alternating fbm_rdy.
        for (int c = 0; c < NCOL; c++) wr_pix(c, 24'(c * 3));
        store(5, 1'b1);
        tick();
        drain(1, 1'b0, -1, 127);

        // Row 7 from buffer A while buffer B is written; then copy B out.
        for (int c = 0; c < NCOL; c++) wr_pix(c, 24'($urandom));
        store(7, 1'b1);
        tick();
        drain(2, 1'b1, -1, 0);
        store(8, 1'b0);
        tick();
        drain(0, 1'b0, -1, 64);

        // Frame swap with coincident vsync: only the later vsync swaps.
        frame_swap = 1'b1;
        disp_vsync = 1'b1;
        tick();
        frame_swap = 1'b0;
        disp_vsync = 1'b0;
        check("t4_frame_rdy_0", frame_rdy, 0);
        check("t4_disp_hold", disp_frame, m_disp);
        repeat (9) tick();
        check("t4_frame_rdy_9", frame_rdy, 0);
        disp_vsync = 1'b1;
        tick();
        disp_vsync = 1'b0;
        m_disp = ~m_disp;
        check("t4_disp_swap", disp_frame, m_disp);
        check("t4_frame_rdy_1", frame_rdy, 1);

        // Vsync during a copy is skipped; repeated frame_swap while pending is inert.
        frame_swap = 1'b1;
        tick();
        tick();
        frame_swap = 1'b0;
        store(9, 1'b0);
        tick();
        drain(0, 1'b0, 10, 64);
        check("t4b_disp_hold", disp_frame, m_disp);
        check("t4b_frame_rdy", frame_rdy, 0);
        disp_vsync = 1'b1;
        tick();
        disp_vsync = 1'b0;
        m_disp = ~m_disp;
        check("t4b_disp_swap", disp_frame, m_disp);
        check("t4b_frame_rdy_1", frame_rdy, 1);
        frame_swap = 1'b1;
        tick();
        frame_swap = 1'b0;
        disp_vsync = 1'b1;
        tick();
        disp_vsync = 1'b0;
        m_disp = ~m_disp;
        check("t4c_disp", disp_frame, m_disp);

        // Store + swap while busy must be ignored.
        store(10, 1'b0);
        check("t5_rdy_busy", fbw_row_rdy, 0);
        fbw_row_store = 1'b1;
        fbw_row_addr  = 6'd11;
        fbw_row_swap  = 1'b1;
        tick();
        fbw_row_store = 1'b0;
        fbw_row_swap  = 1'b0;
        drain(0, 1'b0, -1, 64);

        // Reset in the middle of a copy at column 30, with a frame swap pending.
        store(12, 1'b0);
        tick();
        frame_swap = 1'b1;
        tick();
        frame_swap = 1'b0;
        repeat (29) tick();
        check("t6_pre_addr", fbm_addr, {~m_disp, 6'd12, 6'd30});
        check("t6_pre_we", fbm_we, 1);
        check("t6_pre_frame_rdy", frame_rdy, 0);
        check("t6_pre_disp", disp_frame, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_we", fbm_we, 0);
        check("t6_rst_row_rdy", fbw_row_rdy, 1);
        check("t6_rst_frame_rdy", frame_rdy, 1);
        check("t6_rst_disp", disp_frame, 0);
        check("t6_rst_addr", fbm_addr, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_q.delete();
        m_disp = 1'b0;
        m_fill = 1'b0;
        tick();
        check("t6_post_row_rdy", fbw_row_rdy, 1);
        check("t6_post_frame_rdy", frame_rdy, 1);

        // Fill select restarts at bank 0 after reset; line memory keeps old data.
        for (int c = 0; c < 8; c++) wr_pix(c, 24'($urandom));
        store(1, 1'b0);
        tick();
        drain(0, 1'b0, -1, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
